// File: rtl/net_sequencer.sv
// Sequences a binary two-layer classifier over a one-cycle-latency weight ROM.
// Optional NET_SEQ_THRESH_EN adds a run-time hidden threshold port.
module net_sequencer #(
  parameter int HIDDEN  = 100,
  parameter int OUTPUTS = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [63:0]  in,
`ifdef NET_SEQ_THRESH_EN
  input  logic [6:0]   thresh,
`endif
  output logic         wt_rd,
  output logic [7:0]   wt_addr,
  input  logic [127:0] wt_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [3:0]   digit,
  output logic [15:0]  confidence
);

  localparam int LAST = HIDDEN + OUTPUTS - 1;

  typedef enum logic [2:0] {IDLE, HID, OUT, DRAIN, DONE} state_t;
  state_t state, state_nx;

  logic [63:0]       img;
  logic [6:0]        thr;
  logic [HIDDEN-1:0] hidden;
  logic [1:0]        vld_pipe;   // [0]: ROM data valid now, [1]: score register valid
  logic [7:0]        row_d1;
  logic [7:0]        score;
  logic [3:0]        score_idx;
  logic [7:0]        best;
  logic [3:0]        best_idx;
  logic [7:0]        cand;
  logic [3:0]        cand_idx;
  logic [6:0]        img_match;
  logic [7:0]        hid_match;
  logic              hbit;
  logic              accept;
  logic              last_score;
  logic              unused_data;

  function automatic logic [6:0] pop_img(input logic [63:0] v);
    logic [6:0] c;
    c = '0;
    for (int i = 0; i < 64; i++) c = c + 7'(v[i]);
    return c;
  endfunction

  function automatic logic [7:0] pop_hid(input logic [HIDDEN-1:0] v);
    logic [7:0] c;
    c = '0;
    for (int i = 0; i < HIDDEN; i++) c = c + 8'(v[i]);
    return c;
  endfunction

  assign unused_data = ^wt_data;
  assign in_ready    = (state == IDLE);
  assign out_valid   = (state == DONE);
  assign wt_rd       = (state == HID) || (state == OUT);
  assign accept      = in_valid && in_ready;
  assign last_score  = vld_pipe[1] && (score_idx == 4'(OUTPUTS - 1));

  always_comb begin
    img_match = pop_img(~(img ^ wt_data[63:0]));
    hbit      = (img_match >= thr);
    hid_match = pop_hid(~(hidden ^ wt_data[HIDDEN-1:0]));
    // Class 0 seeds the running best; later classes need a strict win.
    if (score_idx == 4'd0 || score > best) begin
      cand     = score;
      cand_idx = score_idx;
    end else begin
      cand     = best;
      cand_idx = best_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = HID;
      HID:     if (wt_addr == 8'(HIDDEN - 1)) state_nx = OUT;
      OUT:     if (wt_addr == 8'(LAST)) state_nx = DRAIN;
      DRAIN:   if (last_score) state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      img        <= '0;
      thr        <= 7'd32;
      hidden     <= '0;
      vld_pipe   <= '0;
      row_d1     <= '0;
      score      <= '0;
      score_idx  <= '0;
      best       <= '0;
      best_idx   <= '0;
      wt_addr    <= '0;
      digit      <= '0;
      confidence <= '0;
    end else begin
      if (accept) begin
        img <= in;
`ifdef NET_SEQ_THRESH_EN
        thr <= thresh;
`else
        thr <= 7'd32;
`endif
      end
      if (wt_rd) wt_addr <= (wt_addr == 8'(LAST)) ? 8'd0 : wt_addr + 8'd1;
      vld_pipe[0] <= wt_rd;
      row_d1      <= wt_addr;
      if (vld_pipe[0] && row_d1 < 8'(HIDDEN)) begin
        for (int i = 0; i < HIDDEN; i++)
          if (row_d1 == 8'(i)) hidden[i] <= hbit;
      end
      // Output rows always trail the last hidden write by at least one cycle.
      vld_pipe[1] <= vld_pipe[0] && (row_d1 >= 8'(HIDDEN));
      score       <= hid_match;
      score_idx   <= 4'(row_d1 - 8'(HIDDEN));
      if (vld_pipe[1]) begin
        best     <= cand;
        best_idx <= cand_idx;
      end
      if (state == DRAIN && last_score) begin
        digit      <= cand_idx;
        confidence <= {8'd0, cand};
      end
    end
  end

endmodule

// File: tb/tb_net_sequencer.sv
// Self-checking bench for net_sequencer: directed scenarios plus random images/ROMs
// compared against a popcount/argmax reference model.
module tb_net_sequencer;
  localparam int H = 100;
  localparam int O = 10;
  localparam int N = H + O;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [63:0]  img_in;
  logic         wt_rd;
  logic [7:0]   wt_addr;
  logic [127:0] wt_data;
  logic         out_valid;
  logic         out_ready;
  logic [3:0]   digit;
  logic [15:0]  confidence;
`ifdef NET_SEQ_THRESH_EN
  logic [6:0]   thresh;
`endif

  logic [127:0] rom [256];
  int checks = 0;
  int errors = 0;
  int thr_m  = 32;

  net_sequencer #(.HIDDEN(H), .OUTPUTS(O)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in(img_in),
`ifdef NET_SEQ_THRESH_EN
    .thresh(thresh),
`endif
    .wt_rd(wt_rd), .wt_addr(wt_addr), .wt_data(wt_data),
    .out_valid(out_valid), .out_ready(out_ready), .digit(digit), .confidence(confidence)
  );

  always #5 clk = ~clk;

  // ROM: returns the row one cycle after a read, junk otherwise.
  always @(posedge clk) begin
    if (wt_rd === 1'b1) wt_data <= rom[wt_addr];
    else                wt_data <= {$urandom, $urandom, $urandom, $urandom};
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: hidden bits by match count, then the first class reaching the max score.
  task automatic model(input logic [63:0] im, output logic [3:0] d, output logic [15:0] c);
    logic [H-1:0] hv;
    int sc [O];
    int mx;
    for (int h = 0; h < H; h++) hv[h] = ($countones(~(im ^ rom[h][63:0])) >= thr_m);
    mx = 0;
    for (int k = 0; k < O; k++) begin
      sc[k] = $countones(~(hv ^ rom[H+k][H-1:0]));
      if (sc[k] > mx) mx = sc[k];
    end
    d = 4'd0;
    for (int k = O - 1; k >= 0; k--) if (sc[k] == mx) d = 4'(k);
    c = 16'(mx);
  endtask

  task automatic fill_random();
    for (int r = 0; r < 256; r++) rom[r] = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic accept(input logic [63:0] im);
    img_in   = im;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  // Accepts an image, waits for out_valid and audits the read address stream.
  task automatic run_job(input logic [63:0] im, output int lat, output int bad);
    int cyc;
    accept(im);
    cyc = 0;
    bad = 0;
    while (out_valid !== 1'b1 && cyc < 400) begin
      if (cyc < N) begin
        if (!(wt_rd === 1'b1 && wt_addr === 8'(cyc))) bad++;
      end else if (wt_rd !== 1'b0) bad++;
      tick();
      cyc++;
    end
    lat = cyc;
  endtask

  task automatic job_and_check(input string tag, input logic [63:0] im);
    logic [3:0] d;
    logic [15:0] c;
    int lat, bad;
    model(im, d, c);
    run_job(im, lat, bad);
    check({tag, "_latency"}, 128'(lat), 128'(112));
    check({tag, "_addr_seq"}, 128'(bad), 128'(0));
    check({tag, "_digit"}, 128'(digit), 128'(d));
    check({tag, "_conf"}, 128'(confidence), 128'(c));
  endtask

  initial begin
    logic [3:0]  d;
    logic [15:0] c;
    logic [63:0] im;
    int bad, lat, rdy_cnt, ov_cnt, idx;
    int addrs [$];

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; img_in = '0;
`ifdef NET_SEQ_THRESH_EN
    thresh = 7'd32;
`endif
    for (int r = 0; r < 256; r++) rom[r] = '0;
    tick(); tick();
    check("rst_in_ready", 128'(in_ready), 128'(1));
    check("rst_out_valid", 128'(out_valid), 128'(0));
    check("rst_wt_rd", 128'(wt_rd), 128'(0));
    check("rst_wt_addr", 128'(wt_addr), 128'(0));
    check("rst_digit", 128'(digit), 128'(0));
    check("rst_conf", 128'(confidence), 128'(0));
    rst = 1'b0;
    tick();

    // Single winning class 3.
    rom[H+3] = '1;
    job_and_check("row103", 64'd0);
    check("row103_digit_abs", 128'(digit), 128'(3));
    check("row103_conf_abs", 128'(confidence), 128'(100));
    tick();

    // Tie between classes 2 and 7 keeps the lower index.
    for (int r = 0; r < 256; r++) rom[r] = '0;
    rom[H+2] = '1;
    rom[H+7] = '1;
    job_and_check("tie", 64'd0);
    check("tie_digit_abs", 128'(digit), 128'(2));
    tick();

    // Threshold boundary: 32 matches sets a hidden bit, 31 does not.
    for (int h = 0; h < H; h++) rom[h] = (h % 2 == 0) ? 128'({32'd0, 32'hFFFF_FFFF}) : 128'({31'd0, 33'h1_FFFF_FFFF});
    for (int k = 0; k < O; k++) rom[H+k] = {$urandom, $urandom, $urandom, $urandom};
    job_and_check("thr_edge", 64'd0);
    tick();

    // Random images and ROMs.
    for (int t = 0; t < 4; t++) begin
      fill_random();
      job_and_check($sformatf("rand%0d", t), {$urandom, $urandom});
      tick();
    end

    // Reset mid-inference discards the job.
    fill_random();
    accept({$urandom, $urandom});
    for (int i = 0; i < 50; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_in_ready", 128'(in_ready), 128'(1));
    check("midrst_out_valid", 128'(out_valid), 128'(0));
    check("midrst_digit", 128'(digit), 128'(0));
    check("midrst_conf", 128'(confidence), 128'(0));
    tick(); tick();
    check("midrst_idle_rd", 128'(wt_rd), 128'(0));
    job_and_check("after_rst", {$urandom, $urandom});
    tick();

    // Back-pressure: result must hold and new images must be ignored.
    fill_random();
    im = {$urandom, $urandom};
    model(im, d, c);
    out_ready = 1'b0;
    run_job(im, lat, bad);
    check("hold_latency", 128'(lat), 128'(112));
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      in_valid = i[0];
      img_in = {$urandom, $urandom};
      if (!(digit === d && confidence === c && in_ready === 1'b0 && out_valid === 1'b1 && wt_rd === 1'b0)) bad++;
      tick();
    end
    in_valid = 1'b0;
    check("hold_stable", 128'(bad), 128'(0));
    check("hold_digit", 128'(digit), 128'(d));
    out_ready = 1'b1;
    tick();
    check("release_in_ready", 128'(in_ready), 128'(1));
    check("release_out_valid", 128'(out_valid), 128'(0));
    check("idle_hold_digit", 128'(digit), 128'(d));
    check("idle_hold_conf", 128'(confidence), 128'(c));
    tick();
    check("idle_no_rd", 128'(wt_rd), 128'(0));

    // Back-to-back jobs with out_ready tied high.
    fill_random();
    im = {$urandom, $urandom};
    model(im, d, c);
    img_in = im;
    in_valid = 1'b1;
    rdy_cnt = 0; ov_cnt = 0; bad = 0;
    for (int s = 0; s < 228; s++) begin
      tick();
      if (wt_rd === 1'b1) addrs.push_back(int'(wt_addr));
      if (s < 227 && in_ready === 1'b1) rdy_cnt++;
      if (out_valid === 1'b1) begin
        ov_cnt++;
        if (!(digit === d && confidence === c)) bad++;
      end
    end
    in_valid = 1'b0;
    check("b2b_reads", 128'(addrs.size()), 128'(2 * N));
    idx = 0;
    for (int i = 0; i < addrs.size(); i++) if (addrs[i] != i % N) idx++;
    check("b2b_addr_seq", 128'(idx), 128'(0));
    check("b2b_idle_cycles", 128'(rdy_cnt), 128'(1));
    check("b2b_results", 128'(ov_cnt), 128'(2));
    check("b2b_values", 128'(bad), 128'(0));
    tick();

`ifdef NET_SEQ_THRESH_EN
    // Threshold above the maximum match count clears every hidden bit.
    for (int r = 0; r < 256; r++) rom[r] = '0;
    thresh = 7'd65;
    thr_m = 65;
    job_and_check("thr65", 64'd0);
    check("thr65_digit_abs", 128'(digit), 128'(0));
    check("thr65_conf_abs", 128'(confidence), 128'(100));
    tick();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
